uart_wb_master: RTL and testbench
=================================

// Module: uart_wb_master
// PURPOSE
//  Bridge from a UART byte stream to a Wishbone (pipelined) initiator. It gives a host on the
//  serial line read/write access to the on-chip Wishbone bus. It sits between a UART core's
//  RX/TX byte ports and the bus interconnect, on the opposite side of the bus from the UART
//  slave peripherals. Byte-level commands are parsed, one 32-bit bus cycle is issued per
//  command, and a byte-level response is returned.
// PARAMETERS
//  ADDR_W          32    Wishbone address width; only the low ADDR_W bits of the 4 received
//                        address bytes are used.
//  TIMEOUT_CYCLES  1024  Max cycles spent in BUS_REQ+BUS_WAIT before aborting (>=2).
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       synchronous reset, active low
//  rx_data_i    in   8       received byte from UART
//  rx_vld_i     in   1       1-cycle strobe: rx_data_i valid
//  tx_data_o    out  8       byte to transmit
//  tx_vld_o     out  1       tx_data_o valid; held until accepted
//  tx_busy_i    in   1       UART TX busy; byte accepted on cycle tx_vld_o & ~tx_busy_i
//  wb_adr_o     out  ADDR_W  bus address
//  wb_data_m_o  out  32      write data (master->slave)
//  wb_data_s_i  in   32      read data (slave->master)
//  wb_we_o      out  1       1=write
//  wb_sel_o     out  4       byte enables, always 4'hF during a cycle
//  wb_cyc_o     out  1       bus cycle active
//  wb_stb_o     out  1       request strobe
//  wb_stall_i   in   1       slave not accepting request
//  wb_ack_i     in   1       cycle complete OK
//  wb_err_i     in   1       cycle complete with error
//  rx_drop_o    out  1       1-cycle pulse: rx byte discarded (busy or unknown command)
// BEHAVIOUR
//  Reset (rst_ni=0 at clk_i edge): state=IDLE. tx_vld_o, wb_cyc_o, wb_stb_o, wb_we_o and
//   rx_drop_o are 0. tx_data_o, wb_adr_o, wb_data_m_o and wb_sel_o are 0. Byte counter and
//   timeout counter are 0. Reset mid-cycle drops cyc/stb next edge; no response byte is sent.
//  Commands (multi-byte fields MSB first):
//   0x57 'W' + 4 addr + 4 data  -> write cycle
//   0x52 'R' + 4 addr           -> read cycle
//  States:
//   IDLE:     rx 0x57 -> ADDR (we=1); rx 0x52 -> ADDR (we=0); any other byte -> pulse rx_drop_o.
//   ADDR:     shift 4 bytes into addr. After 4th: we=1 -> DATA, else -> BUS_REQ.
//   DATA:     shift 4 bytes into wdata. After 4th -> BUS_REQ.
//   BUS_REQ:  cyc=stb=1, adr/data/we stable. Request accepted on a cycle with stb & ~stall.
//             Next state is BUS_WAIT with stb=0, cyc=1. ack/err on the accept cycle itself are
//             honoured as completion.
//   BUS_WAIT: cyc=1. ack -> latch wb_data_s_i (read), cyc=0 -> RESP. err -> cyc=0 -> RESP(E).
//             ack and err together are treated as err.
//   RESP:     write OK: 1 byte 0x4B. read OK: 4 bytes rdata MSB first. err: 0x45.
//             timeout: 0x54. tx_vld_o=1 with tx_data_o stable until accepted. The next byte is
//             presented on the cycle after acceptance. After the last byte -> IDLE.
//  Timeout: counter clears on entering BUS_REQ and increments each cycle in BUS_REQ/BUS_WAIT.
//   When count reaches TIMEOUT_CYCLES-1 with no ack/err: cyc=stb=0 next edge, then RESP(0x54).
//  Any rx_vld_i outside IDLE/ADDR/DATA pulses rx_drop_o the next cycle. The byte is ignored.
//  Registered outputs only; the first bus strobe appears 1 cycle after the last command byte.
//  Byte counter is 2 bits and wraps 3->0 on the field's final byte.
// TESTING
//  1 rx 57 00 00 10 00 DE AD BE EF, stall=0, ack 2 cyc after stb -> one cycle adr=0x1000
//    we=1 data=0xDEADBEEF sel=F; tx 0x4B.
//  2 rx 52 00 00 00 04, slave returns 0x12345678 with ack -> we=0; tx 12 34 56 78 in order,
//    each held while tx_busy_i=1 for 5 cycles.
//  3 stall=1 for 7 cycles during write -> stb held 8 cycles, addr/data stable; single access.
//  4 read with err=1 -> tx 0x45; cyc low 1 cycle after err. Separately, no ack for
//    TIMEOUT_CYCLES -> cyc drops, tx 0x54.
//  5 rx 0xAA in IDLE, and bytes during BUS_WAIT -> rx_drop_o pulses; a following valid
//    command executes normally.
//  6 rst_ni=0 mid BUS_WAIT and mid RESP -> next edge: cyc=stb=tx_vld=0, IDLE; new command
//    accepted immediately after.

Source files
------------

// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone (pipelined) initiator: parses 'W'/'R' commands, issues one
// 32-bit bus cycle per command and returns a byte-level response.
module uart_wb_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_vld_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_vld_o,
    input  logic              tx_busy_i,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_data_m_o,
    input  logic [31:0]       wb_data_s_i,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              rx_drop_o
);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RspOk    = 8'h4B;
    localparam logic [7:0] RspErr   = 8'h45;
    localparam logic [7:0] RspTmo   = 8'h54;

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StBusReq, StBusWait, StResp} state_e;

    state_e          state_q;
    logic [1:0]      cnt_q;
    logic [TmoW-1:0] tmo_q;
    logic [31:0]     addr_q;
    logic [31:0]     resp_q;
    logic            bus_live;

    assign wb_adr_o = addr_q[ADDR_W-1:0];

    // ack/err only count once the request has been accepted (or is being accepted now)
    assign bus_live = (state_q == StBusWait) || (state_q == StBusReq && !wb_stall_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            tmo_q       <= '0;
            addr_q      <= 32'd0;
            resp_q      <= 32'd0;
            tx_data_o   <= 8'd0;
            tx_vld_o    <= 1'b0;
            wb_data_m_o <= 32'd0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= 4'h0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rx_drop_o   <= 1'b0;
        end else begin
            rx_drop_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_vld_i) begin
                        cnt_q <= 2'd0;
                        if (rx_data_i == CmdWrite) begin
                            wb_we_o <= 1'b1;
                            state_q <= StAddr;
                        end else if (rx_data_i == CmdRead) begin
                            wb_we_o <= 1'b0;
                            state_q <= StAddr;
                        end else begin
                            rx_drop_o <= 1'b1;
                        end
                    end
                end
                StAddr: begin
                    if (rx_vld_i) begin
                        addr_q <= {addr_q[23:0], rx_data_i};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (wb_we_o) begin
                                state_q <= StData;
                            end else begin
                                state_q  <= StBusReq;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_sel_o <= 4'hF;
                                tmo_q    <= '0;
                            end
                        end
                    end
                end
                StData: begin
                    if (rx_vld_i) begin
                        wb_data_m_o <= {wb_data_m_o[23:0], rx_data_i};
                        cnt_q       <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q  <= StBusReq;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= 4'hF;
                            tmo_q    <= '0;
                        end
                    end
                end
                StBusReq, StBusWait: begin
                    if (rx_vld_i) rx_drop_o <= 1'b1;
                    if (state_q == StBusReq && !wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state_q  <= StBusWait;
                    end
                    // Completion beats timeout when both land on the same cycle
                    if (bus_live && (wb_ack_i || wb_err_i)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        tx_vld_o <= 1'b1;
                        state_q  <= StResp;
                        if (wb_err_i) begin
                            tx_data_o <= RspErr;
                            cnt_q     <= 2'd3;
                        end else if (wb_we_o) begin
                            tx_data_o <= RspOk;
                            cnt_q     <= 2'd3;
                        end else begin
                            tx_data_o <= wb_data_s_i[31:24];
                            resp_q    <= {wb_data_s_i[23:0], 8'h00};
                            cnt_q     <= 2'd0;
                        end
                    end else if (tmo_q == TmoLast) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        tx_vld_o  <= 1'b1;
                        tx_data_o <= RspTmo;
                        cnt_q     <= 2'd3;
                        state_q   <= StResp;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rx_vld_i) rx_drop_o <= 1'b1;
                    // cnt_q == 3 marks the final byte; single-byte responses start there
                    if (!tx_busy_i) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            tx_vld_o <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            tx_data_o <= resp_q[31:24];
                            resp_q    <= {resp_q[23:0], 8'h00};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: host/slave models at transaction level plus
// per-cycle bus and TX-stability checks.
module tb_uart_wb_master;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data_i;
    logic        rx_vld_i;
    logic [7:0]  tx_data_o;
    logic        tx_vld_o;
    logic        tx_busy_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_data_m_o;
    logic [31:0] wb_data_s_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        rx_drop_o;

    uart_wb_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data_i), .rx_vld_i(rx_vld_i),
        .tx_data_o(tx_data_o), .tx_vld_o(tx_vld_o), .tx_busy_i(tx_busy_i),
        .wb_adr_o(wb_adr_o), .wb_data_m_o(wb_data_m_o), .wb_data_s_i(wb_data_s_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .rx_drop_o(rx_drop_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Slave configuration for the current transaction; mode 0=ack 1=err 2=silent 3=ack+err
    logic [31:0] sl_adr = 0, sl_dat = 0;
    bit          sl_we = 0;
    int          sl_stall_left = 0, sl_dly = 0, sl_mode = 0;
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    int acc_cnt = 0, last_cyc_len = 0, last_stb_len = 0;
    int pend = 0, wait_n = 0, just_done = 0, run_len = 0, stb_len = 0;

    // Unwritten locations read back as the inverted address
    function automatic logic [31:0] sl_rd(input logic [31:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return ~a;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return ~a;
    endfunction

    task automatic complete();
        if (sl_mode == 0) begin
            wb_ack_i = 1'b1;
            if (sl_we) slave_mem[sl_adr] = sl_dat;
            else wb_data_s_i = sl_rd(sl_adr);
            just_done = 1;
        end else if (sl_mode == 1) begin
            wb_err_i = 1'b1;
            just_done = 1;
        end else if (sl_mode == 3) begin
            wb_ack_i = 1'b1;
            wb_err_i = 1'b1;
            just_done = 1;
        end
    endtask

    // Wishbone slave + per-cycle bus compare
    initial begin
        wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0; wb_data_s_i = 0;
        forever begin
            @(negedge clk);
            wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0; wb_data_s_i = $urandom;
            if (just_done != 0) begin
                check("cyc_drop_after_done", 32'(wb_cyc_o), 32'd0);
                just_done = 0;
            end
            if (!wb_cyc_o) begin
                pend = 0;
                stb_len = 0;
                if (run_len > 0) begin
                    last_cyc_len = run_len;
                    run_len = 0;
                end
            end else begin
                run_len++;
                if (wb_stb_o) begin
                    check("bus_adr", wb_adr_o, sl_adr);
                    check("bus_we", 32'(wb_we_o), 32'(sl_we));
                    check("bus_sel", 32'(wb_sel_o), 32'hF);
                    if (sl_we) check("bus_wdata", wb_data_m_o, sl_dat);
                    stb_len++;
                    if (sl_stall_left > 0) begin
                        wb_stall_i = 1'b1;
                        sl_stall_left--;
                    end else begin
                        acc_cnt++;
                        last_stb_len = stb_len;
                        stb_len = 0;
                        if (sl_dly == 0) complete();
                        else begin
                            pend = 1;
                            wait_n = sl_dly;
                        end
                    end
                end else if (pend != 0) begin
                    wait_n--;
                    if (wait_n == 0) begin
                        pend = 0;
                        complete();
                    end
                end
            end
        end
    end

    // UART TX side: busy_per busy cycles per byte, then accept
    int busy_per = 0, busy_left = 0;
    logic [7:0] got_q[$];
    int acc_cyc_q[$];
    bit hold_v = 0;
    logic [7:0] hold_b = 0;
    initial begin
        tx_busy_i = 0;
        forever begin
            @(negedge clk);
            tx_busy_i = 1'b0;
            if (!tx_vld_o) hold_v = 0;
            else begin
                if (hold_v) check("tx_stable", 32'(tx_data_o), 32'(hold_b));
                else begin
                    hold_v = 1;
                    hold_b = tx_data_o;
                end
                if (busy_left > 0) begin
                    tx_busy_i = 1'b1;
                    busy_left--;
                end else begin
                    got_q.push_back(tx_data_o);
                    acc_cyc_q.push_back(cyc_n);
                    hold_v = 0;
                    busy_left = busy_per;
                end
            end
        end
    end

    int drop_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (rx_drop_o) drop_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_i = b;
        rx_vld_i = 1'b1;
        @(negedge clk);
        rx_vld_i = 1'b0;
        rx_data_i = 8'($urandom);
    endtask

    task automatic send_cmd(input bit we, input logic [31:0] a, input logic [31:0] d);
        send_byte(we ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[8*(3-i) +: 8]);
        if (we) for (int i = 0; i < 4; i++) send_byte(d[8*(3-i) +: 8]);
    endtask

    task automatic do_cmd(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input int stall, input int dly, input int mode, input int busy,
                          input int inject);
        logic [7:0] exp_q[$];
        logic [31:0] w;
        int acc0, drop0, n;
        got_q.delete();
        acc_cyc_q.delete();
        sl_adr = a; sl_dat = d; sl_we = we;
        sl_stall_left = stall; sl_dly = dly; sl_mode = mode;
        busy_per = busy; busy_left = busy;
        acc0 = acc_cnt;
        drop0 = drop_cnt;
        if (mode == 2) exp_q.push_back(8'h54);
        else if (mode != 0) exp_q.push_back(8'h45);
        else if (we) begin
            exp_q.push_back(8'h4B);
            model_mem[a] = d;
        end else begin
            w = model_rd(a);
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*(3-i) +: 8]);
        end
        send_cmd(we, a, d);
        check("stb_after_cmd", 32'({wb_cyc_o, wb_stb_o}), 32'd3);
        for (int i = 0; i < inject; i++) send_byte(8'h57);
        n = 0;
        while (got_q.size() < exp_q.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("resp_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check("resp_byte", 32'(got_q[i]), 32'(exp_q[i]));
        check("accesses", 32'(acc_cnt - acc0), 32'd1);
        check("drops", 32'(drop_cnt - drop0), 32'(inject));
        check("cyc_len", 32'(last_cyc_len), (mode == 2) ? 32'(TMO) : 32'(stall + 1 + dly));
        check("stb_len", 32'(last_stb_len), 32'(stall + 1));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lit;
        int drop0, n, r, mode, dly;
        rst_n = 1'b0;
        rx_vld_i = 1'b0;
        rx_data_i = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_tx_vld", 32'(tx_vld_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_wdata", wb_data_m_o, 32'd0);
        check("rst_drop", 32'(rx_drop_o), 32'd0);
        rst_n = 1'b1;

        do_cmd(1, 32'h1000, 32'hDEADBEEF, 0, 2, 0, 0, 0);
        check("t1_resp", 32'(got_q[0]), 32'h4B);
        check("t1_mem", slave_mem[32'h1000], 32'hDEADBEEF);

        slave_mem[32'h4] = 32'h12345678;
        model_mem[32'h4] = 32'h12345678;
        do_cmd(0, 32'h4, 32'h0, 0, 1, 0, 5, 0);
        lit = 32'h12345678;
        for (int i = 0; i < 4; i++) check("t2_byte", 32'(got_q[i]), 32'(lit[8*(3-i) +: 8]));
        check("t2_span", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 32'd18);
        do_cmd(0, 32'h4, 32'h0, 0, 0, 0, 0, 0);
        check("t2_b2b_span", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 32'd3);

        do_cmd(1, 32'h2000, 32'hCAFEF00D, 7, 1, 0, 0, 0);
        check("t3_stb_len", 32'(last_stb_len), 32'd8);

        do_cmd(0, 32'h30, 32'h0, 0, 2, 1, 0, 0);
        check("t4_err", 32'(got_q[0]), 32'h45);
        do_cmd(0, 32'h34, 32'h0, 0, 0, 2, 0, 0);
        check("t4_tmo", 32'(got_q[0]), 32'h54);
        check("t4_tmo_len", 32'(last_cyc_len), 32'd16);
        do_cmd(1, 32'h38, 32'h1, 0, 1, 3, 0, 0);
        check("t4_ackerr", 32'(got_q[0]), 32'h45);
        check("t4_no_write", 32'(slave_mem.exists(32'h38)), 32'd0);

        drop0 = drop_cnt;
        send_byte(8'hAA);
        check("t5_drop_pulse", 32'(rx_drop_o), 32'd1);
        @(negedge clk);
        check("t5_drop_end", 32'(rx_drop_o), 32'd0);
        check("t5_drop_cnt", 32'(drop_cnt - drop0), 32'd1);
        do_cmd(1, 32'h40, 32'h55AA55AA, 0, 6, 0, 0, 2);
        do_cmd(0, 32'h40, 32'h0, 1, 2, 0, 1, 0);
        check("t5_readback", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h55AA55AA);

        // Reset while waiting for the slave
        sl_adr = 32'h50; sl_we = 0; sl_mode = 2; sl_stall_left = 0; sl_dly = 0;
        send_cmd(0, 32'h50, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6a_cyc", 32'(wb_cyc_o), 32'd0);
        check("t6a_stb", 32'(wb_stb_o), 32'd0);
        check("t6a_tx_vld", 32'(tx_vld_o), 32'd0);
        rst_n = 1'b1;
        do_cmd(0, 32'h1000, 32'h0, 0, 1, 0, 0, 0);

        // Reset while a response byte is held off by tx_busy
        sl_adr = 32'h4; sl_we = 0; sl_mode = 0; sl_stall_left = 0; sl_dly = 1;
        busy_per = 40; busy_left = 40;
        send_cmd(0, 32'h4, 32'h0);
        n = 0;
        while (!tx_vld_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6b_in_resp", 32'(tx_vld_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6b_tx_vld", 32'(tx_vld_o), 32'd0);
        check("t6b_tx_data", 32'(tx_data_o), 32'd0);
        check("t6b_cyc", 32'(wb_cyc_o), 32'd0);
        rst_n = 1'b1;
        busy_per = 0; busy_left = 0;
        do_cmd(1, 32'h60, 32'hA1B2C3D4, 0, 0, 0, 0, 0);

        for (int it = 0; it < 30; it++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'h100 + 32'(4 * $urandom_range(0, 5));
            dly = $urandom_range(0, 6);
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 3 : 2;
            do_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), dly, mode,
                   $urandom_range(0, 2), (dly >= 5 || mode == 2) ? $urandom_range(0, 2) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
